multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Multi-cycle main control FSM for the simple RISC-V core. It sequences the shared ALU, instruction memory, data memory and register file through fetch, decode, execute, memory and writeback steps. It drives the 2-bit ALU_Op and the latched funct3/funct7 fields consumed by the ALU controller, plus all datapath enables.

Parameters:
WAIT_LIMIT, 15, max cycles spent in FETCH or MEM waiting for a memory ready before declaring timeout (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin execution
instr  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  instruction memory read complete
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
ir_we  out  1  instruction register load strobe
pc_we  out  1  PC <= PC+4 strobe
reg_we  out  1  register file write enable
alu_src_imm  out  1  ALU operand B = immediate
mem_to_reg  out  1  writeback selects load data
alu_op  out  2  ALU_Op to ALU controller: 00 I-ALU, 01 load/store ADD, 10 R-type
funct3  out  3  latched instr[14:12]
funct7  out  7  latched instr[31:25]
busy  out  1  high in any state except IDLE/HALT
illegal  out  1  sticky: unsupported opcode seen
timeout  out  1  sticky: memory wait exceeded WAIT_LIMIT
state_dbg  out  3  current state encoding

Behaviour:
- States (encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Registered state; 7 is unreachable and recovers to IDLE.
- Reset (async, rst_n low): state=IDLE. Latched opcode/funct3/funct7=0. Wait counter=0. illegal=0, timeout=0. All strobes 0. alu_op=01. Reset mid-instruction aborts it immediately.
- IDLE: start=1 -> FETCH at the next edge.
- FETCH: imem_req=1. When imem_ready=1, ir_we=1 in that cycle (combinational from imem_ready), latch opcode/funct3/funct7 from instr, -> DECODE.
- DECODE, by latched opcode:
  - 0110011 R-type, 0010011 I-ALU, 0000011 load, 0100011 store -> EXEC.
  - 1110011 (system) -> HALT with illegal unchanged.
  - Any other opcode -> illegal=1, pc_we=1, -> FETCH (instruction skipped).
- EXEC: R-type/I-ALU -> WB. Load/store -> MEM.
- MEM: dmem_req=1, dmem_we=1 for store. On dmem_ready:
  - store -> pc_we=1, -> FETCH.
  - load -> WB.
- WB: reg_we=1, mem_to_reg=1 for load, pc_we=1 -> FETCH.
- HALT: all strobes 0, busy=0. Stays until reset; start is ignored.
- alu_op and alu_src_imm are driven from the latched opcode in DECODE, EXEC, MEM and WB, and are stable across those states:
  - R-type: alu_op=10, alu_src_imm=0.
  - I-ALU: alu_op=00, alu_src_imm=1.
  - Load/store: alu_op=01, alu_src_imm=1.
  - IDLE/FETCH/HALT: alu_op=01, alu_src_imm=0.
- funct3/funct7 hold their value until the next ir_we.
- Wait timer:
  - Counts cycles spent in FETCH/MEM with ready low; clears on state entry and on ready.
  - Ready is accepted in any of the first WAIT_LIMIT cycles of the state.
  - If ready is low on the WAIT_LIMIT-th cycle: -> HALT and timeout=1.
  - Ready arriving in the same cycle as the limit wins (no timeout).
- Latency with ready in the first cycle: R/I = 4 cycles (FETCH, DECODE, EXEC, WB), load = 5, store = 4, illegal = 2.
- Strobes (ir_we, pc_we, reg_we) are single-cycle pulses; at most one pc_we per instruction.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_SYSTEM);
  - ALU_Op encodings (ALUOP_I=00, ALUOP_ADDR=01, ALUOP_R=10);
  - state encoding constants.
- One sub-module, mem_wait_timer: parameter WAIT_LIMIT; inputs clear, count_en; output expired. Counter width $clog2(WAIT_LIMIT+1).

Test Plan:
- Reset, start=1, instr=0x002081B3 (add x3,x1,x2), imem_ready=1 -> states 1,2,3,5; alu_op=10, funct7=0, reg_we=1 and pc_we=1 in WB; 4 cycles; back in FETCH.
- instr=0x0040A183 (lw), dmem_ready delayed 3 cycles -> MEM lasts 4 cycles with dmem_req=1, dmem_we=0; alu_op=01; WB has mem_to_reg=1, reg_we=1.
- instr=0x0030A223 (sw), dmem_ready=1 -> dmem_we=1 for 1 cycle, pc_we=1 in MEM, reg_we never asserted; 4 cycles total.
- instr=0x0000007F (bad opcode) -> illegal=1 sticky, pc_we pulse in DECODE, next state FETCH; next sub instr 0x402081B3 decodes with funct7[5]=1, alu_op=10.
- WAIT_LIMIT=15: imem_ready first high on cycle 15 -> accepted, timeout=0. imem_ready never high -> HALT after 15 FETCH cycles, timeout=1, busy=0.
- Assert rst_n=0 during MEM -> immediate IDLE, all strobes 0, alu_op=01. instr=0x00000073 (ecall) -> HALT; start is then ignored.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle RISC-V control path: opcodes,
// ALU_Op encodings and the FSM state encoding used by the controller.
package riscv_ctrl_pkg;

   typedef logic [6:0] opcode_t;

   localparam opcode_t OP_R      = 7'b0110011;
   localparam opcode_t OP_I      = 7'b0010011;
   localparam opcode_t OP_LOAD   = 7'b0000011;
   localparam opcode_t OP_STORE  = 7'b0100011;
   localparam opcode_t OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] ALUOP_I    = 2'b00;
   localparam logic [1:0] ALUOP_ADDR = 2'b01;
   localparam logic [1:0] ALUOP_R    = 2'b10;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_HALT   = 3'd6;

   // True for the opcodes the datapath can execute (go on to EXEC)
   function automatic logic isExecOp(input opcode_t op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Handshake/control bundle between the multi-cycle controller and the
// rest of the core. The master side feeds memory status and the
// instruction word; the slave side (the controller) drives the strobes.
interface multicycle_controller_if;
   logic        start;
   logic [31:0] instr;
   logic        imem_ready;
   logic        dmem_ready;
   logic        imem_req;
   logic        dmem_req;
   logic        dmem_we;
   logic        ir_we;
   logic        pc_we;
   logic        reg_we;
   logic        alu_src_imm;
   logic        mem_to_reg;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        busy;
   logic        illegal;
   logic        timeout;
   logic [2:0]  state_dbg;

   modport master (
      output start, instr, imem_ready, dmem_ready,
      input  imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src_imm,
             mem_to_reg, alu_op, funct3, funct7, busy, illegal, timeout, state_dbg
   );

   modport slave (
      input  start, instr, imem_ready, dmem_ready,
      output imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src_imm,
             mem_to_reg, alu_op, funct3, funct7, busy, illegal, timeout, state_dbg
   );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts consecutive cycles spent waiting on a memory ready and flags the
// cycle on which the WAIT_LIMIT-th wait cycle would pass without ready.
module mem_wait_timer #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

   logic [CW-1:0] r_count;

   // Wait counter: holds the number of earlier not-ready cycles in this wait
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (count_en && (r_count != LAST)) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign expired = count_en && (r_count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM: sequences fetch, decode, execute, memory
// and writeback, drives datapath strobes and the ALU_Op/funct fields.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input logic                   clk,
   input logic                   rst_n,
   multicycle_controller_if.slave bus
);

   logic [2:0] r_state;
   logic [2:0] w_nextState;
   opcode_t    r_opcode;
   logic [2:0] r_funct3;
   logic [6:0] r_funct7;
   logic       r_illegal;
   logic       r_timeout;

   logic       w_setIllegal;
   logic       w_setTimeout;
   logic       w_waitCount;
   logic       w_expired;
   logic       w_isLoad;
   logic       w_isStore;

   logic       w_imemReq;
   logic       w_dmemReq;
   logic       w_dmemWe;
   logic       w_irWe;
   logic       w_pcWe;
   logic       w_regWe;
   logic       w_memToReg;
   logic       w_busy;
   logic [1:0] w_aluOp;
   logic       w_aluSrcImm;

   assign w_isLoad  = (r_opcode == OP_LOAD);
   assign w_isStore = (r_opcode == OP_STORE);

   // Any cycle in FETCH/MEM without ready counts; every other cycle clears,
   // so each new wait state starts counting from zero.
   assign w_waitCount = ((r_state == ST_FETCH) && !bus.imem_ready) ||
                        ((r_state == ST_MEM)   && !bus.dmem_ready);

   mem_wait_timer #(
      .WAIT_LIMIT(WAIT_LIMIT)
   ) u_waitTimer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (!w_waitCount),
      .count_en (w_waitCount),
      .expired  (w_expired)
   );

   // Next-state selection plus the sticky-flag set requests
   always_comb begin
      w_nextState  = r_state;
      w_setIllegal = 1'b0;
      w_setTimeout = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_nextState = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.imem_ready) begin
               w_nextState = ST_DECODE;
            end else if (w_expired) begin
               w_nextState  = ST_HALT;
               w_setTimeout = 1'b1;
            end
         end
         ST_DECODE: begin
            if (isExecOp(r_opcode)) begin
               w_nextState = ST_EXEC;
            end else if (r_opcode == OP_SYSTEM) begin
               w_nextState = ST_HALT;
            end else begin
               w_nextState  = ST_FETCH;
               w_setIllegal = 1'b1;
            end
         end
         ST_EXEC: begin
            w_nextState = (w_isLoad || w_isStore) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            if (bus.dmem_ready) begin
               w_nextState = w_isStore ? ST_FETCH : ST_WB;
            end else if (w_expired) begin
               w_nextState  = ST_HALT;
               w_setTimeout = 1'b1;
            end
         end
         ST_WB:   w_nextState = ST_FETCH;
         ST_HALT: w_nextState = ST_HALT;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // State register; a reset anywhere aborts the current instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nextState;
   end

   // Instruction fields captured on the IR load strobe, held until the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode <= '0;
         r_funct3 <= '0;
         r_funct7 <= '0;
      end else if (w_irWe) begin
         r_opcode <= bus.instr[6:0];
         r_funct3 <= bus.instr[14:12];
         r_funct7 <= bus.instr[31:25];
      end
   end

   // Sticky error flags, only cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_setIllegal) r_illegal <= 1'b1;
         if (w_setTimeout) r_timeout <= 1'b1;
      end
   end

   // Per-state datapath strobes; pc_we fires once on the instruction's last cycle
   always_comb begin
      w_imemReq  = 1'b0;
      w_dmemReq  = 1'b0;
      w_dmemWe   = 1'b0;
      w_irWe     = 1'b0;
      w_pcWe     = 1'b0;
      w_regWe    = 1'b0;
      w_memToReg = 1'b0;
      w_busy     = 1'b1;
      case (r_state)
         ST_IDLE: w_busy = 1'b0;
         ST_FETCH: begin
            w_imemReq = 1'b1;
            w_irWe    = bus.imem_ready;
         end
         ST_DECODE: begin
            w_pcWe = !isExecOp(r_opcode) && (r_opcode != OP_SYSTEM);
         end
         ST_EXEC: ;
         ST_MEM: begin
            w_dmemReq = 1'b1;
            w_dmemWe  = w_isStore;
            w_pcWe    = w_isStore && bus.dmem_ready;
         end
         ST_WB: begin
            w_regWe    = 1'b1;
            w_memToReg = w_isLoad;
            w_pcWe     = 1'b1;
         end
         ST_HALT: w_busy = 1'b0;
         default: ;
      endcase
   end

   // ALU control derived from the latched opcode while an instruction is in flight
   always_comb begin
      w_aluOp     = ALUOP_ADDR;
      w_aluSrcImm = 1'b0;
      if ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
          (r_state == ST_MEM) || (r_state == ST_WB)) begin
         case (r_opcode)
            OP_R: w_aluOp = ALUOP_R;
            OP_I: begin
               w_aluOp     = ALUOP_I;
               w_aluSrcImm = 1'b1;
            end
            OP_LOAD, OP_STORE: w_aluSrcImm = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.imem_req    = w_imemReq;
   assign bus.dmem_req    = w_dmemReq;
   assign bus.dmem_we     = w_dmemWe;
   assign bus.ir_we       = w_irWe;
   assign bus.pc_we       = w_pcWe;
   assign bus.reg_we      = w_regWe;
   assign bus.alu_src_imm = w_aluSrcImm;
   assign bus.mem_to_reg  = w_memToReg;
   assign bus.alu_op      = w_aluOp;
   assign bus.funct3      = r_funct3;
   assign bus.funct7      = r_funct7;
   assign bus.busy        = w_busy;
   assign bus.illegal     = r_illegal;
   assign bus.timeout     = r_timeout;
   assign bus.state_dbg   = r_state;

endmodule
